// File: rtl/snowbro2_eeprom_pkg.sv
// Shared constants for the 93C46-style x16 serial EEPROM responder.
// Holds the instruction encodings and the controller state type.
package snowbro2_eeprom_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    localparam logic [1:0] EWEN = 2'b11;
    localparam logic [1:0] EWDS = 2'b00;
    localparam logic [1:0] ERAL = 2'b10;
    localparam logic [1:0] WRAL = 2'b01;

    localparam logic [15:0] ERASED_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DATAIN,
        ST_ARMED,
        ST_READOUT,
        ST_PROG,
        ST_STATUS
    } state_t;

endpackage

// File: rtl/snowbro2_eeprom_ram.sv
// 2^AW x DW two-port RAM; port A serves the serial controller, port B the dump port.
// A port B write takes the cycle when both ports write.
module snowbro2_eeprom_ram #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    input  logic          we_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    input  logic          we_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Array contents survive reset; only the read registers clear.
    always_ff @(posedge clk) begin
        if (we_b)
            mem[addr_b] <= din_b;
        else if (we_a)
            mem[addr_a] <= din_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= mem[addr_a];
            q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/snowbro2_eeprom.sv
// Serial EEPROM responder (93C46 x16) for the 68K bit-banged port, with a
// parallel dump port for NVRAM load/save.
module snowbro2_eeprom
    import snowbro2_eeprom_pkg::*;
#(
    parameter int AW          = 6,
    parameter int DW          = 16,
    parameter int BUSY_CYCLES = 1024
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          SCLK,
    input  logic          SCS,
    input  logic          SDI,
    output logic          SDO,
    input  logic [AW-1:0] DUMP_ADDR,
    input  logic [DW-1:0] DUMP_DIN,
    input  logic          DUMP_WE,
    output logic [DW-1:0] DUMP_DOUT,
    output logic          BUSY
);

    localparam int CNT_W = $clog2(DW);
    localparam int BW    = $clog2(BUSY_CYCLES + 1);

    logic [2:0]       sync_p0, sync_p1;
    logic             sclk_p2;
    logic             scs_s, sdi_s, shift;
    state_t           state;
    logic             wen, sdo, busy, wr_pend, prog_all;
    logic [1:0]       opcode;
    logic [AW-1:0]    addr, addr_next;
    logic [DW-1:0]    prog_word, ram_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [BW-1:0]    busy_cnt;
    logic             we_a, stall;

    // Stage p0/p1: two-flop synchronizer, p2: SCLK history for edge detect
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sclk_p2 <= 1'b0;
        end else begin
            sync_p0 <= {SCLK, SCS, SDI};
            sync_p1 <= sync_p0;
            sclk_p2 <= sync_p1[2];
        end
    end

    assign scs_s     = sync_p1[1];
    assign sdi_s     = sync_p1[0];
    assign shift     = sync_p1[2] & ~sclk_p2 & scs_s;
    assign addr_next = {addr[AW-2:0], sdi_s};
    assign we_a      = (state == ST_PROG) && wr_pend;
    assign stall     = we_a && DUMP_WE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            wen       <= 1'b0;
            sdo       <= 1'b1;
            busy      <= 1'b0;
            wr_pend   <= 1'b0;
            prog_all  <= 1'b0;
            opcode    <= '0;
            addr      <= '0;
            prog_word <= '0;
            bit_cnt   <= '0;
            busy_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sdo <= 1'b1;
                    if (shift && sdi_s) begin
                        state   <= ST_OPCODE;
                        opcode  <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_OPCODE: begin
                    sdo <= 1'b1;
                    if (!scs_s) begin
                        state <= ST_IDLE;
                    end else if (shift) begin
                        opcode <= {opcode[0], sdi_s};
                        if (bit_cnt == CNT_W'(1)) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    sdo <= 1'b1;
                    if (!scs_s) begin
                        state <= ST_IDLE;
                    end else if (shift) begin
                        addr <= addr_next;
                        if (bit_cnt == CNT_W'(AW - 1)) begin
                            bit_cnt <= '0;
                            case (opcode)
                                OP_READ: begin
                                    state   <= ST_READOUT;
                                    bit_cnt <= CNT_W'(DW - 1);
                                    sdo     <= 1'b0;
                                end
                                OP_WRITE: begin
                                    state    <= ST_DATAIN;
                                    prog_all <= 1'b0;
                                end
                                OP_ERASE: begin
                                    state     <= ST_ARMED;
                                    prog_all  <= 1'b0;
                                    prog_word <= DW'(ERASED_WORD);
                                end
                                default: begin
                                    case (addr_next[AW-1:AW-2])
                                        EWEN: begin
                                            wen   <= 1'b1;
                                            state <= ST_IDLE;
                                        end
                                        EWDS: begin
                                            wen   <= 1'b0;
                                            state <= ST_IDLE;
                                        end
                                        ERAL: begin
                                            state     <= ST_ARMED;
                                            prog_all  <= 1'b1;
                                            prog_word <= DW'(ERASED_WORD);
                                        end
                                        default: begin
                                            state    <= ST_DATAIN;
                                            prog_all <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATAIN: begin
                    sdo <= 1'b1;
                    if (!scs_s) begin
                        state <= ST_IDLE;
                    end else if (shift) begin
                        prog_word <= {prog_word[DW-2:0], sdi_s};
                        if (bit_cnt == CNT_W'(DW - 1))
                            state <= ST_ARMED;
                        else
                            bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    sdo <= 1'b1;
                    if (!scs_s) begin
                        if (wen) begin
                            state    <= ST_PROG;
                            busy     <= 1'b1;
                            busy_cnt <= BW'(BUSY_CYCLES - 1);
                            wr_pend  <= 1'b1;
                            if (prog_all)
                                addr <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_READOUT: begin
                    if (!scs_s) begin
                        state <= ST_IDLE;
                        sdo   <= 1'b1;
                    end else if (shift) begin
                        sdo <= ram_q[bit_cnt];
                        if (bit_cnt == '0) begin
                            addr    <= addr + AW'(1);
                            bit_cnt <= CNT_W'(DW - 1);
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_PROG: begin
                    sdo <= scs_s ? ~busy : 1'b1;
                    // A dump write steals the RAM cycle: hold both the address and the busy count.
                    if (we_a && !DUMP_WE) begin
                        if (!prog_all || addr == '1)
                            wr_pend <= 1'b0;
                        else
                            addr <= addr + AW'(1);
                    end
                    if (!stall) begin
                        if (busy_cnt == '0) begin
                            if (!wr_pend) begin
                                busy  <= 1'b0;
                                state <= ST_STATUS;
                            end
                        end else begin
                            busy_cnt <= busy_cnt - BW'(1);
                        end
                    end
                end
                default: begin
                    sdo <= scs_s ? ~busy : 1'b1;
                    if (!scs_s) begin
                        state <= ST_IDLE;
                    end else if (shift && sdi_s) begin
                        state   <= ST_OPCODE;
                        opcode  <= '0;
                        bit_cnt <= '0;
                    end
                end
            endcase
        end
    end

    snowbro2_eeprom_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk    (CLK),
        .rst    (RESET),
        .addr_a (addr),
        .din_a  (prog_word),
        .we_a   (we_a),
        .q_a    (ram_q),
        .addr_b (DUMP_ADDR),
        .din_b  (DUMP_DIN),
        .we_b   (DUMP_WE),
        .q_b    (DUMP_DOUT)
    );

    assign SDO  = sdo;
    assign BUSY = busy;

endmodule

// File: tb/tb_snowbro2_eeprom.sv
// Directed bench for snowbro2_eeprom: serial instructions driven bit by bit,
// memory inspected through the dump port.
module tb_snowbro2_eeprom;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SCLK = 1'b0;
    logic        SCS = 1'b0;
    logic        SDI = 1'b0;
    logic        SDO;
    logic [5:0]  DUMP_ADDR = '0;
    logic [15:0] DUMP_DIN = '0;
    logic        DUMP_WE = 1'b0;
    logic [15:0] DUMP_DOUT;
    logic        BUSY;

    int vectors = 0;
    int miscompares = 0;

    snowbro2_eeprom dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCLK      (SCLK),
        .SCS       (SCS),
        .SDI       (SDI),
        .SDO       (SDO),
        .DUMP_ADDR (DUMP_ADDR),
        .DUMP_DIN  (DUMP_DIN),
        .DUMP_WE   (DUMP_WE),
        .DUMP_DOUT (DUMP_DOUT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic shift_bit(input logic b, output logic so);
        @(negedge CLK);
        SDI  = b;
        SCLK = 1'b0;
        repeat (3) @(negedge CLK);
        SCLK = 1'b1;
        repeat (4) @(negedge CLK);
        so = SDO;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, output logic so);
        for (int i = n - 1; i >= 0; i--)
            shift_bit(v[i], so);
    endtask

    task automatic read_word(output logic [15:0] w);
        logic so;
        for (int i = 15; i >= 0; i--) begin
            shift_bit(1'b0, so);
            w[i] = so;
        end
    endtask

    task automatic cs_on();
        @(negedge CLK);
        SCS  = 1'b1;
        SCLK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic cs_off();
        @(negedge CLK);
        SCS  = 1'b0;
        SCLK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic dump_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge CLK);
        DUMP_ADDR = a;
        DUMP_DIN  = d;
        DUMP_WE   = 1'b1;
        @(negedge CLK);
        DUMP_WE   = 1'b0;
    endtask

    task automatic dump_read(input logic [5:0] a, output logic [15:0] d);
        @(negedge CLK);
        DUMP_ADDR = a;
        @(negedge CLK);
        d = DUMP_DOUT;
    endtask

    // Drops SCS, counts BUSY-high cycles, and probes SDO while busy and after ready.
    task automatic measure_busy(input int stall_at, output int cnt,
                                output logic sdo_busy, output logic sdo_ready);
        cnt = 0;
        sdo_busy = 1'b1;
        @(negedge CLK);
        SCS  = 1'b0;
        SCLK = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (BUSY) cnt++;
            DUMP_WE = (i == stall_at);
            if (i == 100) SCS = 1'b1;
            if (i == 110) sdo_busy = SDO;
        end
        sdo_ready = SDO;
        DUMP_WE = 1'b0;
        cs_off();
    endtask

    task automatic send_ewen();
        logic so;
        cs_on();
        send_bits(32'b100110000, 9, so);
        cs_off();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge CLK);
        vectors++;
        if (SDO !== 1'b1) begin miscompares++; $display("FAIL reset_sdo got %b want 1", SDO); end
        vectors++;
        if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", BUSY); end
        vectors++;
        if (DUMP_DOUT !== 16'h0000) begin miscompares++; $display("FAIL reset_dout got %h want 0000", DUMP_DOUT); end
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_write_no_ewen();
        logic so, sb, sr;
        logic [15:0] d;
        int cnt;
        dump_write(6'd5, 16'hBEEF);
        cs_on();
        send_bits(32'b101000101, 9, so);
        send_bits(32'h1234, 16, so);
        measure_busy(-1, cnt, sb, sr);
        vectors++;
        if (cnt !== 0) begin miscompares++; $display("FAIL noewen_busy got %0d want 0", cnt); end
        dump_read(6'd5, d);
        vectors++;
        if (d !== 16'hBEEF) begin miscompares++; $display("FAIL noewen_mem got %h want beef", d); end
    endtask

    task automatic test_ewen_write();
        logic so, sb, sr;
        logic [15:0] d;
        int cnt;
        send_ewen();
        cs_on();
        send_bits(32'b101000101, 9, so);
        send_bits(32'h1234, 16, so);
        measure_busy(-1, cnt, sb, sr);
        vectors++;
        if (cnt !== 1024) begin miscompares++; $display("FAIL write_busy_len got %0d want 1024", cnt); end
        vectors++;
        if (sb !== 1'b0) begin miscompares++; $display("FAIL write_sdo_busy got %b want 0", sb); end
        vectors++;
        if (sr !== 1'b1) begin miscompares++; $display("FAIL write_sdo_ready got %b want 1", sr); end
        dump_read(6'd5, d);
        vectors++;
        if (d !== 16'h1234) begin miscompares++; $display("FAIL write_mem got %h want 1234", d); end
    endtask

    task automatic test_read_wrap();
        logic so;
        logic [15:0] w0, w1;
        dump_write(6'd63, 16'hA5A5);
        dump_write(6'd0, 16'h5A5A);
        cs_on();
        send_bits(32'b110111111, 9, so);
        read_word(w0);
        read_word(w1);
        cs_off();
        vectors++;
        if (so !== 1'b0) begin miscompares++; $display("FAIL read_dummy got %b want 0", so); end
        vectors++;
        if (w0 !== 16'hA5A5) begin miscompares++; $display("FAIL read_word63 got %h want a5a5", w0); end
        vectors++;
        if (w1 !== 16'h5A5A) begin miscompares++; $display("FAIL read_wrap0 got %h want 5a5a", w1); end
    endtask

    task automatic test_eral_wral();
        logic so, sb, sr;
        logic [15:0] d;
        int cnt;
        send_ewen();
        cs_on();
        send_bits(32'b100100000, 9, so);
        DUMP_ADDR = 6'd40;
        DUMP_DIN  = 16'h1111;
        measure_busy(20, cnt, sb, sr);
        vectors++;
        if (cnt !== 1025) begin miscompares++; $display("FAIL eral_busy_stall got %0d want 1025", cnt); end
        for (int a = 0; a < 64; a++) begin
            dump_read(6'(a), d);
            vectors++;
            if (d !== 16'hFFFF) begin miscompares++; $display("FAIL eral_word%0d got %h want ffff", a, d); end
        end
        cs_on();
        send_bits(32'b100010000, 9, so);
        send_bits(32'h0F0F, 16, so);
        measure_busy(-1, cnt, sb, sr);
        vectors++;
        if (cnt !== 1024) begin miscompares++; $display("FAIL wral_busy got %0d want 1024", cnt); end
        for (int a = 0; a < 64; a++) begin
            dump_read(6'(a), d);
            vectors++;
            if (d !== 16'h0F0F) begin miscompares++; $display("FAIL wral_word%0d got %h want 0f0f", a, d); end
        end
    endtask

    task automatic test_abort();
        logic so, sb, sr;
        logic [15:0] d;
        int cnt;
        dump_write(6'd7, 16'h7E57);
        cs_on();
        send_bits(32'b101000111, 9, so);
        send_bits(32'h1234 >> 7, 9, so);
        measure_busy(-1, cnt, sb, sr);
        vectors++;
        if (cnt !== 0) begin miscompares++; $display("FAIL abort_busy got %0d want 0", cnt); end
        dump_read(6'd7, d);
        vectors++;
        if (d !== 16'h7E57) begin miscompares++; $display("FAIL abort_mem got %h want 7e57", d); end
        cs_on();
        send_bits(32'b110000111, 9, so);
        read_word(d);
        cs_off();
        vectors++;
        if (d !== 16'h7E57) begin miscompares++; $display("FAIL abort_read got %h want 7e57", d); end
    endtask

    task automatic test_reset_mid_wral();
        logic so, sb, sr, rose;
        logic [15:0] d, exp;
        int cnt;
        send_ewen();
        cs_on();
        send_bits(32'b100010000, 9, so);
        send_bits(32'h3C3C, 16, so);
        @(negedge CLK);
        SCS  = 1'b0;
        SCLK = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge CLK);
            rose = BUSY;
        end
        vectors++;
        if (rose !== 1'b1) begin miscompares++; $display("FAIL rst_busy_rise got %b want 1", rose); end
        repeat (20) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        vectors++;
        if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", BUSY); end
        vectors++;
        if (SDO !== 1'b1) begin miscompares++; $display("FAIL rst_mid_sdo got %b want 1", SDO); end
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        for (int a = 0; a < 64; a++) begin
            exp = (a < 20) ? 16'h3C3C : 16'h0F0F;
            dump_read(6'(a), d);
            vectors++;
            if (d !== exp) begin miscompares++; $display("FAIL rst_word%0d got %h want %h", a, d, exp); end
        end
        cs_on();
        send_bits(32'b101011110, 9, so);
        send_bits(32'hDEAD, 16, so);
        measure_busy(-1, cnt, sb, sr);
        vectors++;
        if (cnt !== 0) begin miscompares++; $display("FAIL rst_wen_busy got %0d want 0", cnt); end
        dump_read(6'd30, d);
        vectors++;
        if (d !== 16'h0F0F) begin miscompares++; $display("FAIL rst_wen_mem got %h want 0f0f", d); end
    endtask

    initial begin
        test_reset();
        test_write_no_ewen();
        test_ewen_write();
        test_read_wrap();
        test_eral_wral();
        test_abort();
        test_reset_mid_wral();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
